vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator and pixel output stage. It replaces the fixed 800x600 counter block with a full porch/sync/back-porch model, configurable sync polarity and colour width. It drives the pixel request interface (coordinates plus active flag) towards the frame renderer and registers the returned colour, aligned with sync, onto the VGA pins. It also reports line/frame events and pixel underflow.

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, sync-aligned pixel output stage.
// Optional checkerboard test pattern: define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int   COLOR_W  = 8,
    parameter int   CNT_W    = 11,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [COLOR_W-1:0] pixel_in,
    input  logic               pixel_valid,
    input  logic               underflow_clr,
    output logic [COLOR_W+1:0] vga_out,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               in_viewable,
    output logic               line_start,
    output logic               frame_start,
    output logic               underflow_flag
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [COLOR_W+1:0] VGA_RST = {~HS_POL, ~VS_POL, {COLOR_W{1'b0}}};

    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic [COLOR_W+1:0] vga_q, vga_d;
    logic               uf_q, uf_d;
    logic [COLOR_W-1:0] color_d;
    logic               uf_set;
    logic               hs_act;
    logic               vs_act;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign in_viewable = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign line_start  = (h_cnt_q == '0);
    assign frame_start = line_start && (v_cnt_q == '0);

    assign hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    // Blanking is forced black; the pattern path never reports underflow.
    always_comb begin
        color_d = '0;
        uf_set  = 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (test_mode) begin
            if (in_viewable && (h_cnt_q[5] ^ v_cnt_q[5]))
                color_d = '1;
        end else
`endif
        begin
            if (in_viewable && pixel_valid)
                color_d = pixel_in;
            uf_set = in_viewable && !pixel_valid;
        end
    end

    assign vga_d = {hs_act ? HS_POL : ~HS_POL,
                    vs_act ? VS_POL : ~VS_POL,
                    color_d};

    assign uf_d = uf_set | (uf_q & ~underflow_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            vga_q   <= VGA_RST;
            uf_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            vga_q   <= vga_d;
            uf_q    <= uf_d;
        end
    end

    assign vga_out        = vga_q;
    assign underflow_flag = uf_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen against a cycle-count based raster model.
// Small 14x8 raster, plus an inverted-polarity twin and an optional pattern build.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pv, clr;
    logic [7:0] pin;
    logic [9:0] vo0, vo1;
    logic [10:0] px0, py0, px1, py1;
    logic iv0, ls0, fs0, uf0, iv1, ls1, fs1, uf1;

    vga_timing_gen #(
        .COLOR_W(8), .CNT_W(11),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pixel_in(pin), .pixel_valid(pv), .underflow_clr(clr),
        .vga_out(vo0), .pixel_x(px0), .pixel_y(py0),
        .in_viewable(iv0), .line_start(ls0), .frame_start(fs0),
        .underflow_flag(uf0)
    );

    vga_timing_gen #(
        .COLOR_W(8), .CNT_W(11),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pixel_in(pin), .pixel_valid(pv), .underflow_clr(clr),
        .vga_out(vo1), .pixel_x(px1), .pixel_y(py1),
        .in_viewable(iv1), .line_start(ls1), .frame_start(fs1),
        .underflow_flag(uf1)
    );

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic        rst2;
    logic [9:0]  vo2;
    logic [10:0] px2, py2;
    logic        iv2, ls2, fs2, uf2;

    vga_timing_gen dut2 (
        .clk(clk), .rst(rst2), .test_mode(1'b1),
        .pixel_in(8'h5A), .pixel_valid(1'b0), .underflow_clr(1'b0),
        .vga_out(vo2), .pixel_x(px2), .pixel_y(py2),
        .in_viewable(iv2), .line_start(ls2), .frame_start(fs2),
        .underflow_flag(uf2)
    );
`endif

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endfunction

    // Model: position is pure arithmetic on cycles since the last reset edge.
    int       t = 0;
    bit       mvalid = 0;
    bit [7:0] e_col;
    bit       e_hs, e_vs, e_uf;

    function automatic int mx(int tt); return tt % 14; endfunction
    function automatic int my(int tt); return (tt / 14) % 8; endfunction
    function automatic bit mview(int tt); return mx(tt) < 8 && my(tt) < 4; endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0; mvalid = 1;
            e_col = 0; e_hs = 0; e_vs = 0; e_uf = 0;
        end else if (mvalid) begin
            e_col = (mview(t) && pv) ? pin : 8'h00;
            e_hs  = mx(t) >= 10 && mx(t) <= 12;
            e_vs  = my(t) >= 5 && my(t) <= 6;
            e_uf  = (mview(t) && !pv) ? 1'b1 : (clr ? 1'b0 : e_uf);
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("px", px0, mx(t));
            chk("py", py0, my(t));
            chk("view", iv0, mview(t));
            chk("ls", ls0, mx(t) == 0);
            chk("fs", fs0, t % 112 == 0);
            chk("col", vo0[7:0], e_col);
            chk("hs", vo0[9], e_hs);
            chk("vs", vo0[8], e_vs);
            chk("uf", uf0, e_uf);
            chk("hs_inv", vo1[9], !e_hs);
            chk("vs_inv", vo1[8], !e_vs);
            chk("col_inv", vo1[7:0], e_col);
            chk("px_inv", px1, mx(t));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nom();
        pin = 8'(mx(t) * 16 + my(t));
        pv  = 1'b1;
        clr = 1'b0;
    endtask

    task automatic goto(int pos);
        int n = 0;
        drive_nom();
        while (t % 112 != pos && n < 300) begin
            cyc();
            drive_nom();
            n++;
        end
        if (n >= 300) chk("goto_timeout", n, 0);
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; pin = 8'h00; clr = 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        rst2 = 1'b1;
`endif
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 113; i++) begin
            drive_nom();
            @(negedge clk);
            if (i == 0)   chk("lit_fs0", fs0, 1);
            if (i == 112) chk("lit_fs112", fs0, 1);
            if (i == 10)  chk("lit_hs10", vo0[9], 0);
            if (i == 11)  chk("lit_hs11", vo0[9], 1);
            if (i == 11)  chk("lit_hsinv11", vo1[9], 0);
            if (i == 13)  chk("lit_hs13", vo0[9], 1);
            if (i == 14)  chk("lit_hs14", vo0[9], 0);
            if (i == 70)  chk("lit_vs70", vo0[8], 0);
            if (i == 71)  chk("lit_vs71", vo0[8], 1);
            if (i == 98)  chk("lit_vs98", vo0[8], 1);
            if (i == 99)  chk("lit_vs99", vo0[8], 0);
            if (i == 18)  chk("lit_col31", vo0[7:0], 8'h31);
            if (i == 9)   chk("lit_col_hblank", vo0[7:0], 8'h00);
            cyc();
        end

        goto(17);
        pv = 1'b0;
        cyc();
        drive_nom();
        @(negedge clk);
        chk("lit_uf_col", vo0[7:0], 8'h00);
        chk("lit_uf_set", uf0, 1);
        goto(30);
        @(negedge clk);
        chk("lit_uf_hold", uf0, 1);
        goto(33);
        pv = 1'b0; clr = 1'b1;
        cyc();
        drive_nom();
        @(negedge clk);
        chk("lit_uf_setwins", uf0, 1);
        goto(38);
        clr = 1'b1;
        cyc();
        drive_nom();
        @(negedge clk);
        chk("lit_uf_clr", uf0, 0);

        goto(81);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive_nom();
        @(negedge clk);
        chk("lit_rst_px", px0, 0);
        chk("lit_rst_py", py0, 0);
        chk("lit_rst_view", iv0, 1);
        chk("lit_rst_fs", fs0, 1);
        chk("lit_rst_sync", vo0[9:8], 2'b00);
        chk("lit_rst_col", vo0[7:0], 8'h00);
        for (int i = 0; i < 112; i++) begin
            cyc();
            drive_nom();
        end

        for (int i = 0; i < 1500; i++) begin
            cyc();
            pin = 8'($urandom);
            pv  = ($urandom % 8) != 0;
            clr = ($urandom % 16) == 0;
            rst = ($urandom % 200) == 0;
        end
        cyc();
        rst = 1'b0;
        drive_nom();
        cyc();

`ifdef VGA_TIMING_TEST_PATTERN_EN
        rst2 = 1'b0;
        repeat (33) cyc();
        chk("lit_pat_x", px2, 33);
        chk("lit_pat_on", vo2[7:0], 8'hFF);
        chk("lit_pat_uf0", uf2, 0);
        repeat (33280) cyc();
        chk("lit_pat_y", py2, 32);
        chk("lit_pat_off", vo2[7:0], 8'h00);
        chk("lit_pat_uf1", uf2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
